// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
// Holds the per-channel FSM state encoding and the counter width rule.
// Imported by debounce_channel and input_debouncer.
package debounce_pkg;

  // Per-channel qualification state.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  // Counter width: clog2 of the qualification length, never below one bit.
  // The counter only needs to reach STABLE_CYCLES-1, so clog2 is enough.
  function automatic int unsigned db_cnt_w(input int unsigned stable_cycles);
    int unsigned w;
    w = $clog2(stable_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Purpose: debounce one synchronized input bit and flag its accepted edges.
// Latency: q flips on the STABLE_CYCLES-th consecutive differing sample; pulses align with the new q.
// Backpressure: none; the channel consumes one sample per clock unconditionally.
// Optional feature macro: DEBOUNCE_EDGE_EN adds the rise/fall pulse registers and evt_nxt.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_sync,
  output logic q
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall,
  output logic evt_nxt
`endif
);

  localparam int unsigned      CNT_W    = db_cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               INSTANT  = (STABLE_CYCLES == 1);

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  // Next-state logic: a sample matching q always drops back to STABLE with
  // no credit kept; a run of differing samples commits on its last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (state_q == DB_STABLE) begin
      if (d_sync != q_q) begin
        if (INSTANT) begin
          q_d = d_sync;
        end else begin
          state_d = DB_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
    end else begin
      if (d_sync == q_q) begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        q_d     = d_sync;
        state_d = DB_STABLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end
  end

  // State, counter and debounced bit; reset discards any partial qualification.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      q_q     <= RESET_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q = q_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // An event is simply a committed change of q; direction picks the pulse.
  always_comb begin
    rise_d  = q_d & ~q_q;
    fall_d  = ~q_d & q_q;
    evt_nxt = q_d ^ q_q;
  end

  // Pulse registers so rise/fall appear in the same cycle as the new q.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Purpose: per-bit debounce of a synchronized input bus with rise/fall/changed events.
// Latency: q updates STABLE_CYCLES edges after a new value first appears; all outputs registered.
// Backpressure: none; one sample per clock per channel, events are fire-and-forget pulses.
// Optional feature macro: DEBOUNCE_EDGE_EN enables rise/fall/changed; otherwise they are tied low.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned            WIDTH         = 4,
  parameter int unsigned            STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0]       RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_sync,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] evt_nxt;
  logic             changed_q, changed_d;
`endif

  // One independent channel per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .d_sync  (d_sync[i]),
      .q       (q[i])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise    (rise[i]),
      .fall    (fall[i]),
      .evt_nxt (evt_nxt[i])
`endif
    );
  end

`ifdef DEBOUNCE_EDGE_EN
  // Reduce the channels' next-cycle events so changed lines up with rise/fall.
  always_comb begin
    changed_d = |evt_nxt;
  end

  // Single summary flag, one cycle per event cycle regardless of how many bits moved.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule
